// File: rtl/misr_seq_ctrl.sv
// MISR sequencer CSR bank: on START clears the MISR, compacts for COUNT cycles, captures the signature.
// Latency: reads return one cycle after re_i; sequence busy for COUNT+2 cycles. No backpressure; strobes always accepted.
// Optional interrupt output enabled by defining MISR_SEQ_CTRL_IRQ_EN.
module misr_seq_ctrl #(
    parameter int NBIT_MISR_DATA = 64,
    parameter int NBIT_MISR_ADDR = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      re_i,
    input  logic                      we_i,
    input  logic [NBIT_MISR_ADDR-1:0] addr_i,
    input  logic [NBIT_MISR_DATA-1:0] wdata_i,
    output logic [NBIT_MISR_DATA-1:0] rdata_o,
    output logic                      rvalid_o,
    output logic                      misr_clear_o,
    output logic                      misr_en_o,
    input  logic [NBIT_MISR_DATA-1:0] misr_sig_i,
    output logic                      busy_o,
    output logic                      done_o
`ifdef MISR_SEQ_CTRL_IRQ_EN
    ,
    output logic                      irq_o
`endif
);

    localparam int IDX_LSB = $clog2(NBIT_MISR_DATA / 8);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE
    } state_t;

    state_t                    state;
    logic [CNT_WIDTH-1:0]      count;
    logic [CNT_WIDTH-1:0]      remaining;
    logic [NBIT_MISR_DATA-1:0] signature;
    logic [NBIT_MISR_DATA-1:0] rd_mux;
    logic                      aborted;
    logic [1:0]                idx;
    logic                      wr_ctrl;
    logic                      start;
    logic                      abort;
    logic                      clr_done;
    logic                      busy;
    logic                      unused_bits;
`ifdef MISR_SEQ_CTRL_IRQ_EN
    logic                      irq_en;
`endif

    assign idx         = addr_i[IDX_LSB+1:IDX_LSB];
    assign wr_ctrl     = we_i && (idx == 2'd0);
    assign start       = wr_ctrl && wdata_i[0];
    assign abort       = wr_ctrl && wdata_i[1];
    assign clr_done    = wr_ctrl && wdata_i[2];
    assign busy        = (state != IDLE);
    assign busy_o      = busy;
    assign unused_bits = ^{addr_i, wdata_i};

    always_comb begin
        rd_mux = '0;
        case (idx)
            2'd0: begin
                rd_mux[0] = busy;
                rd_mux[1] = done_o;
                rd_mux[2] = aborted;
`ifdef MISR_SEQ_CTRL_IRQ_EN
                rd_mux[3] = irq_en;
`endif
            end
            2'd1:    rd_mux[CNT_WIDTH-1:0] = count;
            2'd2:    rd_mux = signature;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            count        <= '0;
            remaining    <= '0;
            signature    <= '0;
            aborted      <= 1'b0;
            done_o       <= 1'b0;
            rdata_o      <= '0;
            rvalid_o     <= 1'b0;
            misr_clear_o <= 1'b0;
            misr_en_o    <= 1'b0;
`ifdef MISR_SEQ_CTRL_IRQ_EN
            irq_en       <= 1'b0;
            irq_o        <= 1'b0;
`endif
        end else begin
            // A simultaneous read and write is treated as a write only
            rvalid_o <= re_i && !we_i;
            if (re_i && !we_i)
                rdata_o <= rd_mux;

            if (we_i && (idx == 2'd1) && !busy)
                count <= wdata_i[CNT_WIDTH-1:0];

            if (clr_done) begin
                done_o  <= 1'b0;
                aborted <= 1'b0;
            end

`ifdef MISR_SEQ_CTRL_IRQ_EN
            if (wr_ctrl)
                irq_en <= wdata_i[3];
            irq_o <= clr_done ? 1'b0 : (done_o && irq_en);
`endif

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state        <= CLEAR;
                        remaining    <= count;
                        misr_clear_o <= 1'b1;
                    end
                end
                CLEAR: begin
                    misr_clear_o <= 1'b0;
                    if (abort) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end else if (remaining != '0) begin
                        state     <= RUN;
                        misr_en_o <= 1'b1;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        misr_en_o <= 1'b0;
                        aborted   <= 1'b1;
                    end else begin
                        remaining <= remaining - CNT_WIDTH'(1);
                        // Leave on the last enabled cycle so COUNT never wraps
                        if (remaining == CNT_WIDTH'(1)) begin
                            state     <= CAPTURE;
                            misr_en_o <= 1'b0;
                        end
                    end
                end
                CAPTURE: begin
                    signature <= misr_sig_i;
                    done_o    <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    misr_clear_o <= 1'b0;
                    misr_en_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/misr_seq_ctrl.md
# misr_seq_ctrl

Per-channel sequencer for a MISR signature peripheral, sitting behind the AXI address decoder on one `re`/`we` pair of its MISR select outputs. It implements a three-register CSR bank: CTRL/STATUS, COUNT and SIGNATURE. On a software START it clears the MISR, enables compaction for exactly COUNT cycles, captures the resulting signature and raises a sticky done flag. Two instances, one per MISR channel, serve the two decoder select bits.

## Interface
- `NBIT_MISR_DATA`, 64, CSR/data width; word stride = NBIT_MISR_DATA/8 bytes
- `NBIT_MISR_ADDR`, 64, address width from the decoder
- `CNT_WIDTH`, 32, width of COUNT and the remaining-cycle counter (≤ NBIT_MISR_DATA)
- `clk_i`  in  1  clock; single clock domain
- `rst_ni`  in  1  reset, asynchronous, active-low
- `re_i`  in  1  CSR read strobe (one bit of the decoder's MISR read select)
- `we_i`  in  1  CSR write strobe (one bit of the decoder's MISR write select)
- `addr_i`  in  NBIT_MISR_ADDR  byte address from the decoder
- `wdata_i`  in  NBIT_MISR_DATA  write data
- `rdata_o`  out  NBIT_MISR_DATA  registered read data
- `rvalid_o`  out  1  read data valid, one-cycle pulse
- `misr_clear_o`  out  1  synchronous clear to the MISR
- `misr_en_o`  out  1  compaction enable to the MISR
- `misr_sig_i`  in  NBIT_MISR_DATA  current MISR state
- `busy_o`  out  1  high while the sequence is in CLEAR, RUN or CAPTURE
- `done_o`  out  1  sticky completion flag

## Operation
- CSR index = addr_i[log2(stride)+1 : log2(stride)]. Index 0 is CTRL/STATUS, 1 is COUNT, 2 is SIGNATURE. Index 3 reads 0 and ignores writes. All other address bits are ignored.
- CTRL write bits (self-clearing, never stored):
  - bit0 START
  - bit1 ABORT
  - bit2 CLR_DONE, clears the done and aborted flags
- CTRL read bits: bit0 busy, bit1 done, bit2 aborted. All other bits read 0.
- COUNT: read/write, low CNT_WIDTH bits, upper bits read 0. Writes are ignored while busy.
- SIGNATURE: read-only; writes are ignored.
- FSM states: IDLE, CLEAR, RUN, CAPTURE.
  - IDLE: a START moves to CLEAR and loads the remaining counter from COUNT.
  - CLEAR (1 cycle): misr_clear_o=1. Goes to RUN if COUNT≠0, otherwise to CAPTURE.
  - RUN: misr_en_o=1 and the counter decrements each cycle. Goes to CAPTURE after the cycle in which the counter reaches 1.
  - CAPTURE (1 cycle): SIGNATURE←misr_sig_i, done←1, then back to IDLE.
- START while busy is ignored.
- ABORT in CLEAR or RUN: go to IDLE next cycle, aborted←1, done and SIGNATURE unchanged. ABORT in CAPTURE or IDLE has no effect.
- START and ABORT in the same write: ABORT wins and no sequence starts.
- START with CLR_DONE in the same write: flags clear and the sequence starts.
- re_i and we_i in the same cycle: treated as a write, rvalid_o stays 0.
- Reset values: all outputs 0, FSM in IDLE, COUNT=0, SIGNATURE=0, done=aborted=0. Reset asserted mid-sequence returns to IDLE immediately and deasserts misr_en_o and misr_clear_o asynchronously.

## Timing
- CSR write takes effect on the clock edge sampling we_i.
- Read: re_i sampled at edge T gives rdata_o/rvalid_o valid during cycle T+1. Data is the register value before any same-edge update. rdata_o holds its last value when rvalid_o=0.
- START sampled at edge T:
  - CLEAR during T+1.
  - misr_en_o high for exactly COUNT cycles, T+2 … T+1+COUNT.
  - CAPTURE during T+2+COUNT, sampling misr_sig_i at its end.
  - done_o=1 and busy_o=0 from T+3+COUNT.
- COUNT=0: CLEAR at T+1, CAPTURE at T+2, done at T+3.
- busy_o and the CTRL busy bit are combinational from the state; done_o is registered.
- Counter never wraps: the maximum COUNT of 2^CNT_WIDTH−1 runs exactly that many cycles.

## Configuration
- Macro `MISR_SEQ_CTRL_IRQ_EN`.
- Defined:
  - Adds port `irq_o` (out, 1).
  - Adds CTRL bit3 IRQ_EN, read/write and stored.
  - irq_o = done & IRQ_EN, registered, reset 0, cleared by CLR_DONE.
- Undefined: no irq_o port; CTRL bit3 writes are ignored and read 0.

## Test plan
- Reset, then read all CSRs → rvalid one cycle after each re_i; data 0,0,0; busy_o=done_o=0.
- Write COUNT=5, START at edge T → misr_clear_o high at T+1; misr_en_o high at T+2…T+6 (5 cycles); SIGNATURE equals misr_sig_i at the end of T+7; done_o=1 at T+8; CTRL reads 0x2.
- COUNT=0, START → no misr_en_o pulse; SIGNATURE = misr_sig_i sampled at T+2; done at T+3.
- COUNT=100, START, ABORT at cycle 10 of RUN → misr_en_o low next cycle; CTRL reads 0x4; SIGNATURE unchanged; START+ABORT in one write from IDLE starts nothing.
- While busy: write COUNT=7, START, SIGNATURE=0xFF → all ignored; the running sequence completes with the original COUNT; CLR_DONE afterwards gives CTRL=0.
- With `MISR_SEQ_CTRL_IRQ_EN`: IRQ_EN=1 plus a sequence → irq_o rises one cycle after done_o and falls after CLR_DONE; without the macro, CTRL bit3 reads 0.
